// File: rtl/mux4_scan_ctrl_pkg.sv
// Shared types and sizing for the mux_4to1 scan sequencer.
package mux4_scan_pkg;
  localparam int SEL_W      = 2;
  localparam int N_IN       = 4;
  localparam int SETTLE_MAX = 15;
  localparam int CNT_W      = $clog2(SETTLE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } scan_state_e;
endpackage

// File: rtl/mux4_scan_ctrl_if.sv
// Downstream word handshake of mux4_scan_ctrl; data_parity exists only with MUX4_SCAN_PARITY_EN.
interface mux4_scan_ctrl_if;
  import mux4_scan_pkg::*;
  logic [N_IN-1:0] data;
  logic            data_valid;
  logic            data_ready;
`ifdef MUX4_SCAN_PARITY_EN
  logic            data_parity;

  modport master (output data, output data_valid, output data_parity, input data_ready);
  modport slave  (input data, input data_valid, input data_parity, output data_ready);
`else
  modport master (output data, output data_valid, input data_ready);
  modport slave  (input data, input data_valid, output data_ready);
`endif
endinterface

// File: rtl/mux4_scan_ctrl.sv
// Steps sel through the four mux inputs, samples each after SETTLE_CYCLES and offers the word.
// Optional MUX4_SCAN_PARITY_EN adds a registered XOR of the captured word.
module mux4_scan_ctrl
  import mux4_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mux_out,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  mux4_scan_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_IN - 1);

  scan_state_e      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-2:0]  work_q, work_d;
  logic [N_IN-1:0]  data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      work_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          sel_d   = '0;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          // last sample bypasses work so the word is complete on the same edge
          if (sel_q != SEL_LAST) begin
            work_d[sel_q] = mux_out;
            sel_d         = sel_q + 1'b1;
          end else begin
            data_d  = {mux_out, work_q};
            sel_d   = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.data_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel            = sel_q;
  assign busy           = (state_q == SETTLE);
  assign bus.data       = data_q;
  assign bus.data_valid = (state_q == HOLD);

`ifdef MUX4_SCAN_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     par_q <= 1'b0;
    else if (state_q == SETTLE && state_d == HOLD) par_q <= ^data_d;
  end

  assign bus.data_parity = par_q;
`endif

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Scoreboard bench for mux4_scan_ctrl at SETTLE_CYCLES=1 (dut0) and 3 (dut1).
module tb_mux4_scan_ctrl;
  import mux4_scan_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0, ready = 1'b0;
  logic [3:0] mux_in = 4'b0;
  logic [1:0] sel0, sel1;
  logic       busy0, busy1, mux_out0, mux_out1;
  int         n_tests = 0, n_fail = 0;
  logic [3:0] q0[$], q1[$];

  mux4_scan_ctrl_if if0 ();
  mux4_scan_ctrl_if if1 ();
  assign if0.data_ready = ready;
  assign if1.data_ready = ready;

  // mux_4to1 models
  assign mux_out0 = mux_in[sel0];
  assign mux_out1 = mux_in[sel1];

  mux4_scan_ctrl #(.SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mux_out(mux_out0),
    .sel(sel0), .busy(busy0), .bus(if0)
  );
  mux4_scan_ctrl #(.SETTLE_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mux_out(mux_out1),
    .sel(sel1), .busy(busy1), .bus(if1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake happens on the next edge: pop and compare at the negedge before it.
  always @(negedge clk) begin
    if (rst_n && if0.data_valid && ready) begin
      if (q0.size() == 0) chk("sb0_empty", 1, 0);
      else begin
        logic [3:0] e;
        e = q0.pop_front();
        chk("sb0_data", if0.data, e);
`ifdef MUX4_SCAN_PARITY_EN
        chk("sb0_par", if0.data_parity, ^e);
`endif
      end
    end
    if (rst_n && if1.data_valid && ready) begin
      if (q1.size() == 0) chk("sb1_empty", 1, 0);
      else begin
        logic [3:0] e;
        e = q1.pop_front();
        chk("sb1_data", if1.data, e);
`ifdef MUX4_SCAN_PARITY_EN
        chk("sb1_par", if1.data_parity, ^e);
`endif
      end
    end
  end

  // Full scan on dut0 with bounded wait, then accept the word.
  task automatic scan0(input logic [3:0] w);
    bit done;
    mux_in = w;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    q0.push_back(w);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (if0.data_valid) done = 1;
      else tick();
    end
    chk("scan0_timeout", done, 1);
    chk("scan0_data", if0.data, w);
`ifdef MUX4_SCAN_PARITY_EN
    chk("scan0_par", if0.data_parity, ^w);
`endif
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("scan0_dv_fall", if0.data_valid, 0);
  endtask

  initial begin
    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      mux_in = 4'($urandom_range(15, 0));
      start0 = 1'($urandom_range(1, 0));
      start1 = 1'($urandom_range(1, 0));
      ready  = 1'($urandom_range(1, 0));
      tick();
      chk("rst_sel0", sel0, 0);
      chk("rst_busy0", busy0, 0);
      chk("rst_data0", if0.data, 0);
      chk("rst_dv0", if0.data_valid, 0);
      chk("rst_sel1", {busy1, if1.data_valid, if1.data, sel1}, 0);
    end
    start0 = 0; start1 = 0; ready = 0;
    rst_n = 1'b1;
    tick();

    // basic scan, S=1
    mux_in = 4'b1010;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    q0.push_back(4'b1010);
    for (int i = 0; i < 4; i++) begin
      chk("basic_sel", sel0, i);
      chk("basic_busy", busy0, 1);
      chk("basic_dv_lo", if0.data_valid, 0);
      tick();
    end
    chk("basic_dv", if0.data_valid, 1);
    chk("basic_data", if0.data, 4'b1010);
    chk("basic_busy_lo", busy0, 0);
    chk("basic_sel_ret", sel0, 0);

    // backpressure with start ignored in HOLD
    for (int i = 0; i < 10; i++) begin
      mux_in = 4'b0000;
      start0 = (i == 3);
      tick();
      chk("bp_dv", if0.data_valid, 1);
      chk("bp_data", if0.data, 4'b1010);
      chk("bp_busy", busy0, 0);
    end
    start0 = 1'b0;
    ready  = 1'b1;
    tick();
    chk("bp_release_dv", if0.data_valid, 0);
    chk("bp_release_busy", busy0, 0);
    tick();
    chk("bp_no_queue", busy0, 0);
    ready = 1'b0;

    // settle time, S=3
    mux_in = 4'b0110;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    q1.push_back(4'b0110);
    for (int j = 0; j < 12; j++) begin
      chk("settle_sel", sel1, j / 3);
      chk("settle_dv_lo", if1.data_valid, 0);
      tick();
    end
    chk("settle_dv", if1.data_valid, 1);
    chk("settle_data", if1.data, 4'b0110);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("settle_dv_fall", if1.data_valid, 0);

    // assorted words through the scoreboard
    for (int i = 0; i < 4; i++) scan0(4'($urandom_range(15, 0)));
    scan0(4'b0001);
    scan0(4'b1000);

    // reset mid-scan at sel=10
    mux_in = 4'b1111;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    q0.push_back(4'b1111);
    tick();
    tick();
    chk("mid_sel_pre", sel0, 2);
    rst_n = 1'b0;
    #1;
    q0.delete();
    chk("mid_sel", sel0, 0);
    chk("mid_busy", busy0, 0);
    chk("mid_data", if0.data, 0);
    chk("mid_dv", if0.data_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    scan0(4'b1100);

`ifdef MUX4_SCAN_PARITY_EN
    scan0(4'b1011);
    scan0(4'b1010);
`endif

    tick();
    chk("sb0_drained", q0.size(), 0);
    chk("sb1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_scan_ctrl.md
# mux4_scan_ctrl

Sequencer that drives the select lines of the mux_4to1 selector and consumes its single-bit output. It steps `sel` through 00→01→10→11, waits a programmable settle time on each select value, samples `mux_out`, and assembles the four samples into a 4-bit word. The word is then offered downstream on a valid/ready handshake. It sits directly around mux_4to1: `sel` feeds the mux and the mux's `out` returns as `mux_out`.

## Interface
- `SETTLE_CYCLES`, default 1: cycles `sel` is held before sampling; legal range 1..15.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a scan; sampled only in IDLE.
- `mux_out`  in  1  output of mux_4to1 (combinational from `sel`).
- `sel`  out  2  registered select driven to mux_4to1.
- `busy`  out  1  high while scanning (SETTLE).
- `data`  out  4  captured word; bit i = `mux_out` sampled with `sel`=i.
- `data_valid`  out  1  high while `data` is offered (HOLD).
- `data_ready`  in  1  downstream accept.

## Operation
- Reset values: `sel`=00, `busy`=0, `data`=0000, `data_valid`=0, internal work register and settle counter cleared, state IDLE.
- **IDLE:** If `start`=1 at the clock edge: go to SETTLE, with `sel`=00 and counter=0. `data` keeps its last value.
- **SETTLE (`busy`=1):**
  - While counter < `SETTLE_CYCLES`-1: increment the counter.
  - When counter = `SETTLE_CYCLES`-1: work[`sel`] <= `mux_out` and counter <= 0.
  - If `sel`<11: `sel` <= `sel`+1.
  - If `sel`=11: `data` <= {`mux_out`, work[2:0]}, `data_valid` <= 1, `sel` <= 00, go to HOLD.
- **HOLD (`data_valid`=1, `busy`=0):**
  - `data` is stable.
  - When `data_ready`=1 at the edge, go to IDLE and `data_valid` <= 0.
  - `start` is ignored, not queued.
- `data_ready` is ignored outside HOLD.
- `start` is ignored in SETTLE.
- Reset mid-scan: outputs and state return to reset values immediately. The partial word is discarded and `data` is cleared to 0000.
- `sel` never wraps during a scan. It returns to 00 only on completion or reset.

## Timing
- `start` is accepted at edge N.
  - `sel`=i for edges N+i·S .. N+(i+1)·S, where S = `SETTLE_CYCLES`.
  - Sample i is taken at edge N+(i+1)·S.
- `data_valid` rises after edge N+4·S. Latency is 4·S cycles.
- Handshake completes at the first edge with `data_valid`=1 and `data_ready`=1. `data_valid` falls after that edge.
- Earliest next `start` acceptance is the edge after the handshake edge. Back-to-back throughput is one word per 4·S+2 cycles.
- Because `mux_out` is combinational from registered `sel`, every sample sees at least one full cycle of settled `sel`.

## Configuration
- Macro `MUX4_SCAN_PARITY_EN`.
  - Defined: adds output port `data_parity` (out, 1).
    - It is registered together with `data`, equal to XOR of the four captured bits.
    - Reset value 0; stable in HOLD.
  - Undefined: port and logic are absent. All other behaviour is identical.

## Structure
- Package `mux4_scan_pkg` holds:
  - state typedef (IDLE, SETTLE, HOLD)
  - `SEL_W`=2, `N_IN`=4
  - `SETTLE_MAX`=15
- No sub-module. The FSM, settle counter and work register form one module.
- mux_4to1 is instantiated alongside it, in the bench and at integration, not inside.

## Test plan
- **Reset:** hold `rst_n`=0 with random inputs → `sel`=00, `busy`=0, `data`=0000, `data_valid`=0.
- **Basic scan:** `SETTLE_CYCLES`=1, mux in=1010, pulse `start` → `sel` 00,01,10,11 on consecutive cycles; `data_valid` 4 cycles after the start edge with `data`=1010.
- **Backpressure:** `data_ready`=0 for 10 cycles with `start` pulsed during HOLD → `data`=1010 and `data_valid`=1 held, no new scan; then `data_ready`=1 → IDLE next cycle.
- **Settle time:** `SETTLE_CYCLES`=3, in=0110 → each `sel` held 3 cycles; `data_valid` after 12 cycles, `data`=0110.
- **Reset mid-scan:** assert `rst_n`=0 while `sel`=10 → immediate reset values; a fresh `start` with in=1100 yields `data`=1100.
- **Parity:** with `MUX4_SCAN_PARITY_EN`, in=1011 → `data_parity`=1; in=1010 → 0; without the macro, the port is absent and the build is clean.
